// File: rtl/booth_multiplier_seq_pkg.sv
// rtl/booth_multiplier_seq_pkg.sv - shared types and constants for the sequential Booth multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Recode of {Q[0], Q_1}; 00 and 11 leave the accumulator untouched.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// rtl/booth_multiplier_seq_if.sv - operand/product handshake bundle for booth_multiplier_seq
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   signed_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     p;
  logic                   busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/booth_multiplier_seq_step.sv
// rtl/booth_multiplier_seq_step.sv - one radix-2 Booth recode/add/arithmetic-shift iteration
module booth_step
  import booth_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W:0]   acc,
  input  logic [W-1:0] q,
  input  logic         q_1,
  input  logic [W-1:0] m,
  output logic [W:0]   acc_next,
  output logic [W-1:0] q_next,
  output logic         q_1_next
);

  logic [W:0]     m_ext;
  logic [W:0]     sum;
  logic [2*W+1:0] cat;

  assign m_ext = {m[W-1], m};

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      BOOTH_ADD: sum = acc + m_ext;
      BOOTH_SUB: sum = acc - m_ext;
      default:   sum = acc;
    endcase
  end

  assign cat = {sum, q, q_1};
  assign {acc_next, q_next, q_1_next} = {cat[2*W+1], cat[2*W+1:1]};

endmodule

// File: rtl/booth_multiplier_seq.sv
// rtl/booth_multiplier_seq.sv - multi-cycle Booth multiplier, one iteration per clock, signed/unsigned per op
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  booth_multiplier_seq_if.slave bus
);

  localparam int W  = WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [W-1:0]       m_q;
  logic [W-1:0]       q_q;
  logic               q1_q;
  logic [W:0]         acc_q;
  logic [2*WIDTH-1:0] p_q;

  logic [W:0]         acc_n;
  logic [W-1:0]       q_n;
  logic               q1_n;
  logic [2*WIDTH-1:0] prod_n;

  booth_step #(.W(W)) u_step (
    .acc      (acc_q),
    .q        (q_q),
    .q_1      (q1_q),
    .m        (m_q),
    .acc_next (acc_n),
    .q_next   (q_n),
    .q_1_next (q1_n)
  );

  // Low 2N bits of {ACC,Q} after the final iteration.
  assign prod_n = {acc_n[WIDTH-2:0], q_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
      acc_q <= '0;
      p_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            m_q   <= bus.signed_mode ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
            q_q   <= bus.signed_mode ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
            q1_q  <= 1'b0;
            acc_q <= '0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_n;
          q_q   <= q_n;
          q1_q  <= q1_n;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            p_q   <= prod_n;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb/tb_booth_multiplier_seq.sv - directed and model-checked bench for booth_multiplier_seq
module tb_booth_multiplier_seq;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;
  int   lat, t0, t1, bad;
  logic [7:0]         ra, rb;
  logic               rsm;
  logic signed [15:0] sa, sb;
  logic [15:0]        exp_p;

  booth_multiplier_seq_if #(.WIDTH(WIDTH)) bus ();

  booth_multiplier_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called and returns on a falling edge; the accept edge follows the return-1 negedge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tbv, input logic sm);
    int n = 0;
    bus.a           = ta;
    bus.b           = tbv;
    bus.signed_mode = sm;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(bus.in_ready), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int l);
    l = 0;
    while (!bus.out_valid && l < 50) begin
      @(negedge clk);
      l++;
    end
    check("result_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                    input logic sm, input logic [15:0] expv);
    int l;
    send(ta, tbv, sm);
    wait_result(l);
    check({tag, "_latency"}, 32'(l), 32'd9);
    check(tag, 32'(bus.p), 32'(expv));
    take();
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_p",         32'(bus.p),         32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    op("signed_m3x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1);
    op("unsigned_253x5", 8'hFD, 8'h05, 1'b0, 16'h04F1);
    op("signed_80x80",  8'h80, 8'h80, 1'b1, 16'h4000);
    op("unsigned_FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    op("signed_7Fx80",  8'h7F, 8'h80, 1'b1, 16'hC080);
    op("signed_xzero",  8'hFD, 8'h00, 1'b1, 16'h0000);
    op("unsigned_zerox", 8'h00, 8'hAB, 1'b0, 16'h0000);

    // Backpressure with stray operands offered during RUN and DONE.
    send(8'h0C, 8'h0B, 1'b1);
    bus.a = 8'hAA; bus.b = 8'h55; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd9);
    repeat (5) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_p",         32'(bus.p),         32'h0084);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    take();
    bad = 0;
    repeat (12) begin
      if (bus.out_valid || bus.busy) bad = 1;
      @(negedge clk);
    end
    check("bp_no_second_result", 32'(bad), 32'd0);

    // Abort with reset landing on the fourth iteration edge.
    send(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_ready_during_rst", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_p",         32'(bus.p),         32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_busy",      32'(bus.busy),      32'd0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) bad = 1;
    end
    check("abort_no_result", 32'(bad), 32'd0);
    op("after_abort_12x34", 8'h12, 8'h34, 1'b0, 16'h03A8);

    // Minimum issue interval: consumer always ready, next op offered immediately.
    send(8'h03, 8'h04, 1'b0);
    t0 = acc_cyc;
    wait_result(lat);
    check("mii_p0", 32'(bus.p), 32'h000C);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(8'h05, 8'hFA, 1'b1);
    t1 = acc_cyc;
    check("min_issue_interval", 32'(t1 - t0), 32'(WIDTH + 3));
    wait_result(lat);
    check("mii_p1", 32'(bus.p), 32'hFFE2);
    take();

    for (int i = 0; i < 64; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rsm = 1'($urandom);
      sa  = $signed(ra);
      sb  = $signed(rb);
      exp_p = rsm ? 16'(sa * sb) : ({8'h00, ra} * {8'h00, rb});
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(ra, rb, rsm);
      wait_result(lat);
      check("rand_latency", 32'(lat), 32'd9);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rand_p", 32'(bus.p), 32'(exp_p));
      take();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_seq.md
# booth_multiplier_seq

Parametrised, multi-cycle radix-2 Booth multiplier with valid/ready handshakes on both sides and a per-operation signed/unsigned mode. It performs one Booth recode/add/shift iteration per clock. It replaces the fixed 4-bit combinational multiplier in arithmetic datapaths where area matters more than latency. One operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 8, operand width N (≥2); product is 2N bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and mode valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2*WIDTH  product, low 2N bits of exact result.
- busy  out  1  operation in progress (state RUN or DONE).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, go to RUN.
  - RUN: perform one iteration per cycle. Leave for DONE when the iteration counter reaches N+1 iterations.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Acceptance latches a, b and signed_mode. Input changes after acceptance are ignored. in_valid is ignored outside IDLE.
- Internal operand width is W=N+1. Both operands are sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to W bits, so one datapath serves both modes.
- Registers:
  - M: W bits, the extended a.
  - Q: W bits, the extended b.
  - Q_1: 1 bit, reset to 0 at accept.
  - ACC: W+1 bits, cleared at accept. The extra bit guarantees no overflow when subtracting M = -2^N.
- Each iteration:
  - {Q[0],Q_1} = 01: ACC += sign-extended M.
  - {Q[0],Q_1} = 10: ACC -= sign-extended M.
  - 00 or 11: no change.
  - Then arithmetic-shift-right the concatenation {ACC,Q,Q_1} by one.
- After W iterations, p = low 2N bits of {ACC,Q}. This is exact for signed N×N and unsigned N×N.
- p is registered and loaded on entry to DONE. It holds stable while out_valid && !out_ready and keeps its last value in IDLE.
- Reset values: state IDLE, out_valid 0, p 0, busy 0, counter 0. in_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- rst during RUN or DONE aborts the operation. No out_valid is produced for it.

## Timing
- Accept at edge E0; iterations at edges E1..E(N+1).
- out_valid is high from E(N+1), i.e. N+1 cycles after accept (9 for WIDTH=8).
- The DONE→IDLE handshake takes one edge. The next accept is possible at the following edge. Minimum issue interval is N+3 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- in_ready is a decode of the state register.

## Structure
- Package booth_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the Booth recode constants (01 = ADD, 10 = SUB);
  - a localparam helper for counter width, $clog2(WIDTH+2).
- Sub-module booth_step (combinational, parametrised on W) does one recode/add/shift:
  - inputs: ACC, Q, Q_1, M;
  - outputs: next ACC, Q, Q_1.
- The top module holds the FSM, counter, operand registers, handshake logic and output register.

## Test plan
All scenarios use WIDTH=8.
- Signed: a=0xFD (-3), b=0x05, signed_mode=1 -> p=0xFFF1. out_valid asserts exactly 9 cycles after accept.
- Unsigned: same a and b, signed_mode=0 -> p=0x04F1 (253×5=1265).
- Corners:
  - signed 0x80×0x80 -> 0x4000;
  - unsigned 0xFF×0xFF -> 0xFE01;
  - signed 0x7F×0x80 -> 0xC080;
  - any operand ×0 -> 0x0000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. p and out_valid stay stable, and in_ready stays 0. in_valid with new operands during RUN or DONE is ignored, and no second result appears.
- Reset mid-operation: assert rst for one cycle at iteration 4. out_valid never rises, p=0, and in_ready=1 on the next cycle. A following operation 0x12×0x34 (unsigned) -> 0x03A8.
- Back-to-back: 64 random operand/mode pairs with random in_valid/out_ready gaps, checked against a reference model. Also check the N+3 minimum issue interval.
